sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO. Successor to the team's fixed 8-bit FIFO.
- Generalised data width and depth. Adds programmable almost-full/almost-empty margins, a live occupancy count, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the buffering element between single-clock producer/consumer blocks. Its flag set matches the existing FIFO testbench (full, empty, almost_full, almost_empty, overflow, underflow).

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 24 ++
 rtl/sync_fifo_param.sv | 117 +++++++++++
 tb/tb_sync_fifo_param.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, read-mode enum and sizing helper for the parametrised FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_AF_MARGIN  = 2;
  localparam int unsigned DEF_AE_MARGIN  = 2;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable almost-flags, occupancy count and
// selectable standard / first-word-fall-through read mode.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AF_MARGIN  = DEF_AF_MARGIN,
  parameter int unsigned AE_MARGIN  = DEF_AE_MARGIN,
  parameter int unsigned FWFT       = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_enbl,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_enbl,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [cnt_width(DEPTH)-1:0]    count,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam fifo_mode_e  MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Accept decisions, pointer wrap, occupancy and flag next-state.
  always_comb begin
    wr_acc   = wr_enbl & ~full_q;
    rd_acc   = rd_enbl & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    af_d     = (count_d >= CW'(DEPTH - AF_MARGIN));
    ae_d     = (count_d <= CW'(AE_MARGIN));
    ovf_d    = wr_enbl & full_q;
    unf_d    = rd_enbl & empty_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      // Registered read data, updated only on an accepted pop.
      always_ff @(posedge clk) begin
        if (rst)         rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= mem_rdata;
      end
      assign rd_data = rd_data_q;
    end else begin : g_fwft
      // Head word shown directly; forced to zero while empty so reset reads 0.
      assign rd_data = empty_q ? '0 : mem_rdata;
    end
  endgenerate

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a standard-mode and an FWFT-mode FIFO driven by identical stimulus.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_enbl = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_enbl = 1'b0;

  logic [7:0] s_rd_data, f_rd_data;
  logic [4:0] s_count, f_count;
  logic s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH (8), .DEPTH (16), .AF_MARGIN (2), .AE_MARGIN (2), .FWFT (0)
  ) u_std (
    .clk (clk), .rst (rst), .wr_enbl (wr_enbl), .wr_data (wr_data),
    .rd_enbl (rd_enbl), .rd_data (s_rd_data), .count (s_count),
    .full (s_full), .empty (s_empty), .almost_full (s_af),
    .almost_empty (s_ae), .overflow (s_ovf), .underflow (s_unf)
  );

  sync_fifo_param #(
    .DATA_WIDTH (8), .DEPTH (16), .AF_MARGIN (2), .AE_MARGIN (2), .FWFT (1)
  ) u_fwft (
    .clk (clk), .rst (rst), .wr_enbl (wr_enbl), .wr_data (wr_data),
    .rd_enbl (rd_enbl), .rd_data (f_rd_data), .count (f_count),
    .full (f_full), .empty (f_empty), .almost_full (f_af),
    .almost_empty (f_ae), .overflow (f_ovf), .underflow (f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_ae",    s_ae, 1);
    chk("rst_full",  s_full, 0);
    chk("rst_af",    s_af, 0);
    chk("rst_ovf",   s_ovf, 0);
    chk("rst_unf",   s_unf, 0);
    chk("rst_rdata", s_rd_data, 8'h00);
    chk("rst_f_rdata", f_rd_data, 8'h00);
    rst = 1'b0;

    // 2. fill with 0x00..0x0F, then one rejected write
    for (int i = 0; i < 16; i++) begin
      wr_enbl = 1'b1;
      wr_data = 8'(i);
      tick();
      chk("fill_count", s_count, i + 1);
      chk("fill_ae",    s_ae,   (i + 1 <= 2)  ? 1 : 0);
      chk("fill_af",    s_af,   (i + 1 >= 14) ? 1 : 0);
      chk("fill_full",  s_full, (i + 1 == 16) ? 1 : 0);
      if (i == 0) chk("fill_f_head", f_rd_data, 8'h00);
    end
    wr_data = 8'hAA;
    tick();
    chk("ovf_pulse", s_ovf, 1);
    chk("ovf_count", s_count, 16);
    chk("ovf_full",  s_full, 1);
    wr_enbl = 1'b0;
    tick();
    chk("ovf_clear", s_ovf, 0);
    chk("ovf_count2", s_count, 16);

    // 3. drain back-to-back, then one rejected read
    rd_enbl = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_data",  s_rd_data, i);
      chk("drain_count", s_count, 15 - i);
      if (i < 15) chk("drain_f_head", f_rd_data, i + 1);
    end
    chk("drain_empty", s_empty, 1);
    chk("drain_unf0",  s_unf, 0);
    tick();
    chk("unf_pulse", s_unf, 1);
    chk("unf_hold",  s_rd_data, 8'h0F);
    chk("unf_count", s_count, 0);
    rd_enbl = 1'b0;
    tick();
    chk("unf_clear", s_unf, 0);
    chk("unf_hold2", s_rd_data, 8'h0F);

    // 4. fill to 5, then 20 cycles of simultaneous read/write
    wr_enbl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h40 + 8'(i);
      tick();
    end
    chk("pre_count", s_count, 5);
    rd_enbl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'h45 + 8'(i);
      tick();
      chk("rw_data",   s_rd_data, 8'h40 + i);
      chk("rw_count",  s_count, 5);
      chk("rw_f_head", f_rd_data, 8'h41 + i);
    end
    wr_enbl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tail_data", s_rd_data, 8'h54 + i);
    end
    rd_enbl = 1'b0;
    chk("tail_empty", s_empty, 1);

    // 5. FWFT fall-through of a single word
    wr_enbl = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_enbl = 1'b0;
    chk("fwft_empty", f_empty, 0);
    chk("fwft_data",  f_rd_data, 8'h3C);
    tick();
    chk("fwft_hold",  f_rd_data, 8'h3C);
    rd_enbl = 1'b1;
    tick();
    rd_enbl = 1'b0;
    chk("fwft_pop_empty", f_empty, 1);
    chk("std_pop_data",   s_rd_data, 8'h3C);

    // 6. reset mid-operation with a write request present
    wr_enbl = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data = 8'h60 + 8'(i);
      tick();
    end
    chk("pre_rst_count", s_count, 9);
    rst = 1'b1;
    wr_data = 8'h99;
    tick();
    rst = 1'b0;
    wr_enbl = 1'b0;
    chk("mrst_count", s_count, 0);
    chk("mrst_empty", s_empty, 1);
    chk("mrst_ae",    s_ae, 1);
    chk("mrst_rdata", s_rd_data, 8'h00);
    chk("mrst_f_empty", f_empty, 1);
    wr_enbl = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_enbl = 1'b0;
    chk("post_count",  s_count, 1);
    chk("post_f_head", f_rd_data, 8'h55);
    rd_enbl = 1'b1;
    tick();
    rd_enbl = 1'b0;
    chk("post_data",  s_rd_data, 8'h55);
    chk("post_empty", s_empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
